mod_reducer: RTL and testbench

MOD_REDUCER -- requirements
Module: mod_reducer

---
 rtl/mod_reducer_if.sv | 33 +++
 rtl/mod_reducer.sv | 103 ++++++++++
 tb/tb_mod_reducer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mod_reducer_if.sv
// Handshake bundle between a product source, the modular reducer and its consumer.
// The reducer takes the slave side; whatever feeds and drains it takes the master side.
interface mod_reducer_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] in_p;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_r;
  logic           busy;

  modport master (
    output in_valid,
    output in_p,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_r,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_p,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_r,
    output busy
  );
endinterface

// File: rtl/mod_reducer.sv
// Sequential reducer: in_p mod Q computed by 2N restoring shift-subtract steps,
// one bit of the product per clock, with a valid/ready handshake on both sides.
module mod_reducer #(
  parameter int N = 16,
  parameter int Q = 12289
) (
  input  logic         clk,
  input  logic         rst,
  mod_reducer_if.slave bus
);

  localparam int             CW   = $clog2(2 * N + 1);
  localparam logic [CW-1:0]  LAST = CW'(2 * N - 1);
  localparam logic [N:0]     QW   = (N + 1)'(Q);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [2*N-1:0] shreg_reg, shreg_next;
  logic [N-1:0]   r_reg, r_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [N-1:0]   out_r_reg, out_r_next;

  // The remainder stays below Q < 2^N, so its top bit is always zero and only
  // the low N bits are stored; the trial value and compare still use N+1 bits.
  logic [N:0]     t;
  logic           t_ge;
  logic [N-1:0]   t_red;

  assign t     = {r_reg, shreg_reg[2*N-1]};
  assign t_ge  = (t >= QW);
  assign t_red = t_ge ? N'(t - QW) : t[N-1:0];

  logic in_ready_c, out_valid_c, busy_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
      out_r_reg <= '0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      r_reg     <= r_next;
      cnt_reg   <= cnt_next;
      out_r_reg <= out_r_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    r_next      = r_reg;
    cnt_next    = cnt_reg;
    out_r_next  = out_r_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          shreg_next = bus.in_p;
          r_next     = '0;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy_c     = 1'b1;
        r_next     = t_red;
        shreg_next = {shreg_reg[2*N-2:0], 1'b0};
        cnt_next   = cnt_reg + CW'(1);
        // The last step's remainder goes straight to the output register.
        if (cnt_reg == LAST) begin
          out_r_next = t_red;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out_r     = out_r_reg;

endmodule

// File: tb/tb_mod_reducer.sv
// Bench for mod_reducer: directed boundary cases, backpressure, reset abort and a
// randomized stall run, all results checked in order against a % reference queue.
module tb_mod_reducer;

  localparam int N     = 16;
  localparam int Q     = 12289;
  localparam int NRAND = 1200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mod_reducer_if #(.N(N)) bus ();

  mod_reducer #(.N(N), .Q(Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then step past the rising edge.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(N'(longint'(bus.in_p) % longint'(Q)));
        accepted++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("result_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("result", 64'(bus.out_r), 64'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [2*N-1:0] p, input logic [N-1:0] expr,
                         input string tag, input int hold);
    int w;
    int lat;
    logic [N-1:0] held;
    bus.in_p      = p;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      step();
      w++;
    end
    check({tag, "_accept_wait"}, 64'(w < 100), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    check({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd32);
    check({tag, "_value"}, 64'(bus.out_r), 64'(expr));
    if (hold > 0) begin
      held = bus.out_r;
      bus.in_valid = 1'b1;
      bus.in_p     = 32'h1234_5678;
      for (int i = 0; i < hold; i++) begin
        step();
        check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_hold_value"}, 64'(bus.out_r), 64'(held));
        check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_idle_in_ready"}, 64'(bus.in_ready), 64'd1);
    $display("txn %s in_p=%0d out_r=%0d latency=%0d", tag, p, expr, lat);
  endtask

  initial begin
    int w;
    int seen;
    int cyc;
    int start;

    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_out_r", 64'(bus.out_r), 64'd0);

    run_one(32'h0000_0000, 16'd0,     "zero",    0);
    run_one(32'd12289,     16'd0,     "q",       0);
    run_one(32'd12290,     16'd1,     "q_plus1", 0);
    run_one(32'd12288,     16'd12288, "q_minus1", 0);
    run_one(32'hFFFF_FFFF, 16'd10951, "all_ones", 0);
    run_one(32'd150994944, 16'd1,     "max_sq",  10);

    // Abort: reset lands on the edge that would perform step 15.
    bus.in_p     = 32'hDEAD_BEEF;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      step();
      w++;
    end
    step();
    bus.in_valid = 1'b0;
    repeat (14) step();
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_out_r", 64'(bus.out_r), 64'd0);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    check("abort_no_out_valid", 64'(seen), 64'd0);
    $display("txn abort in_p=%0d cancelled_after_steps=14", 32'hDEAD_BEEF);
    run_one(32'd12290, 16'd1, "after_abort", 0);

    // Random products with random input gaps and output stalls.
    start = accepted;
    cyc   = 0;
    while ((accepted < start + NRAND || exp_q.size() != 0 || bus.busy || bus.out_valid)
           && cyc < 70000) begin
      bus.in_valid = (accepted < start + NRAND) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       bus.in_p = '0;
        1:       bus.in_p = '1;
        2:       bus.in_p = 32'($urandom_range(0, 3 * Q));
        default: bus.in_p = $urandom;
      endcase
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("random_cycle_budget", 64'(cyc < 70000), 64'd1);
    check("random_accepted", 64'(accepted - start), 64'(NRAND));
    check("random_drained", 64'(exp_q.size()), 64'd0);
    $display("txn random count=%0d cycles=%0d", accepted - start, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
